// File: rtl/ko_overlay_ctrl.sv
// KO banner sequencer and compositor: flash/hold/done timing, dimmed-background overlay, registered OLED pixel.
// Optional macro KO_SHAKE_EN adds a +/-1 column jitter on the text ROM index during FLASH.
module ko_overlay_ctrl #(
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES  = 90,
  parameter logic [15:0] TEXT_TINT    = 16'hF800,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        ko_trigger,
  input  logic        round_ack,
  input  logic [12:0] pixel_index,
  input  logic [15:0] bg_colour,
  input  logic [15:0] text_colour,
  output logic [12:0] text_pixel_index,
  output logic [15:0] oled_colour,
  output logic        overlay_active,
  output logic        round_over
);

  typedef enum logic [1:0] {IDLE, FLASH, HOLD, DONE} state_t;

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
  logic             phase, phase_nxt;
  logic [15:0]      colour_nxt;
  logic             active_nxt, round_over_nxt;

  // Outputs are registered from next-state values so a transition edge
  // already shows the new look on the pixel latched at that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      blink_cnt      <= '0;
      phase          <= 1'b1;
      oled_colour    <= 16'h0000;
      overlay_active <= 1'b0;
      round_over     <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_cnt      <= frame_cnt_nxt;
      blink_cnt      <= blink_cnt_nxt;
      phase          <= phase_nxt;
      oled_colour    <= colour_nxt;
      overlay_active <= active_nxt;
      round_over     <= round_over_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    case (state)
      IDLE: if (ko_trigger) begin
        state_nxt     = FLASH;
        frame_cnt_nxt = '0;
        blink_cnt_nxt = '0;
        phase_nxt     = 1'b1;
      end
      FLASH: if (frame_begin) begin
        if (frame_cnt == FLASH_LAST) begin
          state_nxt     = HOLD;
          frame_cnt_nxt = '0;
          blink_cnt_nxt = '0;
          phase_nxt     = 1'b1;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            phase_nxt     = ~phase;
            blink_cnt_nxt = '0;
          end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
          end
        end
      end
      HOLD: if (frame_begin) begin
        if (frame_cnt == HOLD_LAST) begin
          state_nxt     = DONE;
          frame_cnt_nxt = '0;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      DONE: if (round_ack) begin
        state_nxt     = IDLE;
        frame_cnt_nxt = '0;
        blink_cnt_nxt = '0;
        phase_nxt     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    round_over_nxt = (state == HOLD) && (state_nxt == DONE);
    active_nxt     = (state_nxt != IDLE);
    if (state_nxt == IDLE)
      colour_nxt = bg_colour;
    else if (phase_nxt && (text_colour != 16'h0000))
      colour_nxt = TEXT_TINT;
    else
      colour_nxt = {1'b0, bg_colour[15:12], 1'b0, bg_colour[10:6], 1'b0, bg_colour[4:1]};
  end

`ifdef KO_SHAKE_EN
  logic       shake_neg;
  logic [6:0] col;

  // Offset starts at +1 on entry to FLASH and flips every frame.
  always_ff @(posedge clk) begin
    if (reset)
      shake_neg <= 1'b0;
    else if (state == IDLE && ko_trigger)
      shake_neg <= 1'b0;
    else if (state == FLASH && frame_begin)
      shake_neg <= ~shake_neg;
  end

  assign col = 7'(pixel_index % 13'd96);

  always_comb begin
    text_pixel_index = pixel_index;
    if (state == FLASH) begin
      if (!shake_neg && col != 7'd95)
        text_pixel_index = pixel_index + 13'd1;
      else if (shake_neg && col != 7'd0)
        text_pixel_index = pixel_index - 13'd1;
    end
  end
`else
  assign text_pixel_index = pixel_index;
`endif

endmodule

// File: tb/tb_ko_overlay_ctrl.sv
// Directed bench for ko_overlay_ctrl with a frame-count model of the KO sequence.
module tb_ko_overlay_ctrl;
  localparam int F = 4, B = 2, H = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0, ko_trigger = 1'b0, round_ack = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] bg_colour = '0, text_colour = '0;
  logic [12:0] text_pixel_index;
  logic [15:0] oled_colour;
  logic        overlay_active, round_over;

  ko_overlay_ctrl #(.FLASH_FRAMES(F), .BLINK_FRAMES(B), .HOLD_FRAMES(H),
                    .TEXT_TINT(16'hF800), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .ko_trigger(ko_trigger),
    .round_ack(round_ack), .pixel_index(pixel_index), .bg_colour(bg_colour),
    .text_colour(text_colour), .text_pixel_index(text_pixel_index),
    .oled_colour(oled_colour), .overlay_active(overlay_active), .round_over(round_over));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, frames = 0, ro_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dim(input logic [15:0] c);
    int r, g, b;
    r = int'(c[15:11]); g = int'(c[10:5]); b = int'(c[4:0]);
    return 16'((r / 2) * 2048 + (g / 2) * 32 + (b / 2));
  endfunction

  // Model: the sequence is just "frames counted since the KO was accepted".
  bit          m_valid = 0, m_act = 0, m_ro = 0;
  int          n = 0;
  logic [15:0] m_colour = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; n = 0; m_ro = 0; m_colour = 16'h0000;
    end else begin
      m_ro = 0;
      if (!m_act) begin
        if (ko_trigger) begin m_act = 1; n = 0; end
      end else if (n >= F + H) begin
        if (round_ack) m_act = 0;
      end else if (frame_begin) begin
        n++;
        if (n == F + H) m_ro = 1;
      end
      if (!m_act)
        m_colour = bg_colour;
      else if (((n >= F) || ((n / B) % 2 == 0)) && text_colour != 0)
        m_colour = 16'hF800;
      else
        m_colour = dim(bg_colour);
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    logic [12:0] exp_tpi;
    exp_tpi = pixel_index;
`ifdef KO_SHAKE_EN
    if (m_act && n < F) begin
      if (n % 2 == 0) exp_tpi = (pixel_index % 96 == 95) ? pixel_index : pixel_index + 13'd1;
      else            exp_tpi = (pixel_index % 96 == 0)  ? pixel_index : pixel_index - 13'd1;
    end
`endif
    if (m_valid) begin
      chk("oled_colour", 32'(oled_colour), 32'(m_colour));
      chk("overlay_active", 32'(overlay_active), 32'(m_act));
      chk("round_over", 32'(round_over), 32'(m_ro));
      chk("text_pixel_index", 32'(text_pixel_index), 32'(exp_tpi));
    end
    if (round_over === 1'b1) ro_total++;
  end

  task automatic tick();
    frame_begin = (cyc % 10 == 9);
    if (frame_begin) frames++;
    @(posedge clk); #1;
    cyc++;
    ko_trigger = 0; round_ack = 0; frame_begin = 0;
  endtask

  task automatic wait_frames(input int k);
    int target;
    target = frames + k;
    while (frames < target) tick();
  endtask

  task automatic trigger();
    while (cyc % 10 == 9) tick();
    ko_trigger = 1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset oled", 32'(oled_colour), 32'h0000);
    chk("reset active", 32'(overlay_active), 32'h0);
    reset = 0;

    bg_colour = 16'h1234; text_colour = 16'h0000;
    tick();
    chk("idle passthrough", 32'(oled_colour), 32'h1234);
    chk("idle inactive", 32'(overlay_active), 32'h0);

    text_colour = 16'hFFFF;
    trigger();
    chk("flash tint", 32'(oled_colour), 32'hF800);
    chk("flash active", 32'(overlay_active), 32'h1);
    wait_frames(2);
    chk("blink off dim", 32'(oled_colour), 32'h090A);
    wait_frames(2);
    chk("hold tint", 32'(oled_colour), 32'hF800);

    bg_colour = 16'hFFFF; text_colour = 16'h0000;
    tick();
    chk("hold dim white", 32'(oled_colour), 32'h7BEF);
    wait_frames(3);
    chk("round_over pulse", 32'(round_over), 32'h1);
    tick();
    chk("round_over drop", 32'(round_over), 32'h0);
    chk("done active", 32'(overlay_active), 32'h1);
    chk("round_over count", 32'(ro_total), 32'd1);

    ko_trigger = 1; tick();
    chk("done ignores ko", 32'(overlay_active), 32'h1);
    wait_frames(2);
    chk("done stays dim", 32'(oled_colour), 32'h7BEF);
    bg_colour = 16'h1234; round_ack = 1; tick();
    chk("ack inactive", 32'(overlay_active), 32'h0);
    chk("ack passthrough", 32'(oled_colour), 32'h1234);

    text_colour = 16'hFFFF;
    trigger();
    wait_frames(1);
    reset = 1; tick(); reset = 0;
    chk("mid reset oled", 32'(oled_colour), 32'h0000);
    chk("mid reset active", 32'(overlay_active), 32'h0);
    chk("mid reset round_over", 32'(round_over), 32'h0);

    pixel_index = 13'd300;
    trigger();
`ifdef KO_SHAKE_EN
    chk("shake plus", 32'(text_pixel_index), 32'd301);
`endif
    wait_frames(1);
`ifdef KO_SHAKE_EN
    chk("shake minus", 32'(text_pixel_index), 32'd299);
`endif
    chk("restart still visible", 32'(oled_colour), 32'hF800);
    wait_frames(1);
    pixel_index = 13'd287;
    #1;
    chk("restart blink off", 32'(oled_colour), 32'h090A);
    chk("shake clamp col95", 32'(text_pixel_index), 32'd287);
    wait_frames(2);
    pixel_index = 13'd300;
    #1;
    chk("hold no shake", 32'(text_pixel_index), 32'd300);
    repeat (5) tick();
    chk("no extra round_over", 32'(ro_total), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
